// File: rtl/jtframe_dump_pkg.sv
// Shared definitions for the frame-window capture controller.
// Holds the per-channel mode codes (as driven on ch_mode) and the
// per-channel window state encoding.
package jtframe_dump_pkg;

    // Channel mode codes, two bits per channel on ch_mode
    localparam logic [1:0] MODE_OFF      = 2'd0;
    localparam logic [1:0] MODE_FRAME    = 2'd1;
    localparam logic [1:0] MODE_POSTLOAD = 2'd2;
    localparam logic [1:0] MODE_FREE     = 2'd3;

    // Capture window state of one channel
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } chan_state_e;

endpackage

// File: rtl/jtframe_dump_chan.sv
// One capture channel of the frame-window controller.
// Ports:
//   clk, rst     clock and asynchronous active-high reset
//   vs_fall      frame tick (VS falling edge not masked by a download end)
//   dl_fall      ROM download just finished this clock
//   dwnld        ROM download in progress
//   frame_next   value frame_cnt takes on this frame tick
//   mode         channel mode (OFF / FRAME / POSTLOAD / FREE)
//   start        frame number at which the window opens
//   len          window length in frames, 0 = unlimited
//   en           capture window open (registered)
//   start_pulse  one clock high when the window opens (registered)
//   done         window has closed (registered)
module jtframe_dump_chan
    import jtframe_dump_pkg::*;
#(
    parameter int CW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs_fall,
    input  logic          dl_fall,
    input  logic          dwnld,
    input  logic [CW-1:0] frame_next,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] start,
    input  logic [LW-1:0] len,
    output logic          en,
    output logic          start_pulse,
    output logic          done
);

    chan_state_e   state_r;
    chan_state_e   state_s;
    chan_state_e   case_state_s;
    logic [LW-1:0] rem_r;
    logic [LW-1:0] rem_s;
    logic [1:0]    mode_r;      // mode latched when leaving IDLE
    logic [1:0]    mode_s;
    logic          en_r;
    logic          pulse_r;
    logic          done_r;

    // Next-state logic: normal window progression, then OFF/download overrides
    always_comb begin
        case_state_s = state_r;
        rem_s        = rem_r;
        mode_s       = mode_r;
        case (state_r)
            ST_IDLE: begin
                // new modes are only picked up here
                mode_s = mode;
                case (mode)
                    MODE_FRAME: begin
                        case_state_s = ST_ARMED;
                    end
                    MODE_POSTLOAD: begin
                        if (dl_fall) begin
                            case_state_s = ST_ARMED;
                        end else begin
                            case_state_s = ST_IDLE;
                        end
                    end
                    MODE_FREE: begin
                        case_state_s = ST_ACTIVE;
                        rem_s        = len;
                    end
                    default: begin
                        case_state_s = ST_IDLE;
                    end
                endcase
            end
            ST_ARMED: begin
                // open on the tick at which frame_cnt becomes start
                if (vs_fall && (frame_next == start)) begin
                    case_state_s = ST_ACTIVE;
                    rem_s        = len;
                end else begin
                    case_state_s = ST_ARMED;
                end
            end
            ST_ACTIVE: begin
                // rem==0 means an unlimited window: never counted down
                if (vs_fall && (rem_r == LW'(1))) begin
                    case_state_s = ST_DONE;
                    rem_s        = '0;
                end else if (vs_fall && (rem_r != '0)) begin
                    rem_s = rem_r - LW'(1);
                end else begin
                    rem_s = rem_r;
                end
            end
            ST_DONE: begin
                if (mode != mode_r) begin
                    case_state_s = ST_IDLE;
                end else begin
                    case_state_s = ST_DONE;
                end
            end
            default: begin
                case_state_s = ST_IDLE;
            end
        endcase

        // OFF wins from any state; a new download drops POSTLOAD channels
        if (mode == MODE_OFF) begin
            state_s = ST_IDLE;
        end else if (dwnld && (mode_r == MODE_POSTLOAD) && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
        end else begin
            state_s = case_state_s;
        end
    end

    // State, remaining-frame counter and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rem_r   <= '0;
            mode_r  <= MODE_OFF;
            en_r    <= 1'b0;
            pulse_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            rem_r   <= rem_s;
            mode_r  <= mode_s;
            en_r    <= (state_s == ST_ACTIVE);
            pulse_r <= (state_s == ST_ACTIVE) && (state_r != ST_ACTIVE);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign en          = en_r;
    assign start_pulse = pulse_r;
    assign done        = done_r;

endmodule

// File: rtl/jtframe_dump_ctrl.sv
// Multi-channel frame-window controller for waveform / logic-analyser capture.
// Counts frames on VS falling edges (restarting at the end of a ROM download)
// and drives one capture window per channel.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   vs          vertical sync, active high
//   dwnld       ROM download in progress
//   ch_mode     2 bits per channel: 0 OFF, 1 FRAME, 2 POSTLOAD, 3 FREE
//   ch_start    CW bits per channel: start frame
//   ch_len      LW bits per channel: window length, 0 = unlimited
//   frame_cnt   frames since reset or since the last download end
//   dump_en     per-channel capture window active
//   dump_start  per-channel one-clock pulse on window entry
//   dump_done   per-channel level, high once the window has closed
module jtframe_dump_ctrl
    import jtframe_dump_pkg::*;
#(
    parameter int CH = 4,
    parameter int CW = 32,
    parameter int LW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vs,
    input  logic             dwnld,
    input  logic [2*CH-1:0]  ch_mode,
    input  logic [CW*CH-1:0] ch_start,
    input  logic [LW*CH-1:0] ch_len,
    output logic [CW-1:0]    frame_cnt,
    output logic [CH-1:0]    dump_en,
    output logic [CH-1:0]    dump_start,
    output logic [CH-1:0]    dump_done
);

    logic          vs_l;
    logic          dl_l;
    logic          vs_fall;
    logic          dl_fall;
    logic          frame_tick;
    logic [CW-1:0] frame_next;

    assign vs_fall    = vs_l & ~vs;
    assign dl_fall    = dl_l & ~dwnld;
    // a VS edge coinciding with the download end is swallowed by the restart
    assign frame_tick = vs_fall & ~dl_fall;
    assign frame_next = frame_cnt + CW'(1);

    // Edge-detect history and the frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_l      <= 1'b0;
            dl_l      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vs_l <= vs;
            dl_l <= dwnld;
            if (dl_fall) begin
                frame_cnt <= '0;
            end else if (frame_tick) begin
                frame_cnt <= frame_next;
            end else begin
                frame_cnt <= frame_cnt;
            end
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_chan
        jtframe_dump_chan #(
            .CW (CW),
            .LW (LW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .vs_fall     (frame_tick),
            .dl_fall     (dl_fall),
            .dwnld       (dwnld),
            .frame_next  (frame_next),
            .mode        (ch_mode[k*2 +: 2]),
            .start       (ch_start[k*CW +: CW]),
            .len         (ch_len[k*LW +: LW]),
            .en          (dump_en[k]),
            .start_pulse (dump_start[k]),
            .done        (dump_done[k])
        );
    end

endmodule

// File: tb/tb_jtframe_dump_ctrl.sv
module tb_jtframe_dump_ctrl;

    localparam int CH = 4;
    localparam int CW = 32;
    localparam int LW = 16;

    // bench-side window phases
    localparam int P_IDLE   = 0;
    localparam int P_WAIT   = 1;
    localparam int P_OPEN   = 2;
    localparam int P_CLOSED = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             vs = 1'b0;
    logic             dwnld = 1'b0;
    logic [2*CH-1:0]  ch_mode = '0;
    logic [CW*CH-1:0] ch_start = '0;
    logic [LW*CH-1:0] ch_len = '0;
    logic [CW-1:0]    frame_cnt;
    logic [CH-1:0]    dump_en;
    logic [CH-1:0]    dump_start;
    logic [CH-1:0]    dump_done;

    // small-counter instance for the wrap scenario
    logic          vs4 = 1'b0;
    logic          dw4 = 1'b0;
    logic [1:0]    mode4 = 2'd1;
    logic [3:0]    start4 = 4'd1;
    logic [LW-1:0] len4 = 16'd2;
    logic [3:0]    frame_cnt4;
    logic [0:0]    en4;
    logic [0:0]    st4;
    logic [0:0]    dn4;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [CW-1:0] m_cnt;
    bit            m_vs_l;
    bit            m_dl_l;
    int            m_st[CH];
    int            m_left[CH];
    int            m_lat[CH];
    bit [CH-1:0]   m_en;
    bit [CH-1:0]   m_start;
    bit [CH-1:0]   m_done;

    always #5 clk = ~clk;

    jtframe_dump_ctrl #(.CH(CH), .CW(CW), .LW(LW)) u_dut (
        .clk(clk), .rst(rst), .vs(vs), .dwnld(dwnld),
        .ch_mode(ch_mode), .ch_start(ch_start), .ch_len(ch_len),
        .frame_cnt(frame_cnt), .dump_en(dump_en),
        .dump_start(dump_start), .dump_done(dump_done)
    );

    jtframe_dump_ctrl #(.CH(1), .CW(4), .LW(LW)) u_dut4 (
        .clk(clk), .rst(rst), .vs(vs4), .dwnld(dw4),
        .ch_mode(mode4), .ch_start(start4), .ch_len(len4),
        .frame_cnt(frame_cnt4), .dump_en(en4),
        .dump_start(st4), .dump_done(dn4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = '0;
        m_vs_l = 1'b0;
        m_dl_l = 1'b0;
        m_en    = '0;
        m_start = '0;
        m_done  = '0;
        for (int k = 0; k < CH; k++) begin
            m_st[k]   = P_IDLE;
            m_left[k] = 0;
            m_lat[k]  = 0;
        end
    endtask

    // advance the model by one clock using the inputs about to be sampled
    task automatic model_clock();
        bit vf, df, tick;
        logic [CW-1:0] nf;
        int md, ln;
        logic [CW-1:0] sf;
        vf   = m_vs_l && !vs;
        df   = m_dl_l && !dwnld;
        tick = vf && !df;
        nf   = m_cnt + 1;
        for (int k = 0; k < CH; k++) begin
            md = int'(ch_mode[k*2 +: 2]);
            sf = ch_start[k*CW +: CW];
            ln = int'(ch_len[k*LW +: LW]);
            m_start[k] = 1'b0;
            if (md == 0) begin
                m_st[k] = P_IDLE;
            end else if (dwnld && m_st[k] != P_IDLE && m_lat[k] == 2) begin
                m_st[k] = P_IDLE;
            end else begin
                case (m_st[k])
                    P_IDLE: begin
                        m_lat[k] = md;
                        if (md == 1 || (md == 2 && df)) m_st[k] = P_WAIT;
                        if (md == 3) begin
                            m_st[k] = P_OPEN; m_left[k] = ln; m_start[k] = 1'b1;
                        end
                    end
                    P_WAIT: begin
                        if (tick && nf == sf) begin
                            m_st[k] = P_OPEN; m_left[k] = ln; m_start[k] = 1'b1;
                        end
                    end
                    P_OPEN: begin
                        if (tick && m_left[k] != 0) begin
                            m_left[k]--;
                            if (m_left[k] == 0) m_st[k] = P_CLOSED;
                        end
                    end
                    default: begin
                        if (md != m_lat[k]) m_st[k] = P_IDLE;
                    end
                endcase
            end
            m_en[k]   = (m_st[k] == P_OPEN);
            m_done[k] = (m_st[k] == P_CLOSED);
        end
        m_cnt  = df ? '0 : (tick ? nf : m_cnt);
        m_vs_l = vs;
        m_dl_l = dwnld;
    endtask

    task automatic step(input logic v, input logic d);
        vs    = v;
        dwnld = d;
        model_clock();
        @(posedge clk);
        #1;
        chk("frame_cnt", frame_cnt, m_cnt);
        chk("dump_en", dump_en, m_en);
        chk("dump_start", dump_start, m_start);
        chk("dump_done", dump_done, m_done);
    endtask

    task automatic frame(input logic d);
        step(1'b1, d);
        step(1'b0, d);
    endtask

    task automatic set_ch(input int k, input int md, input int sf, input int ln);
        ch_mode[k*2 +: 2]    = 2'(md);
        ch_start[k*CW +: CW] = CW'(sf);
        ch_len[k*LW +: LW]   = LW'(ln);
    endtask

    initial begin
        int n4;
        model_reset();
        dwnld = 1'b1;
        set_ch(0, 1, 3, 2);
        set_ch(1, 2, 2, 0);
        set_ch(2, 3, 0, 0);
        set_ch(3, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_dump_en", dump_en, 0);
        chk("rst_dump_start", dump_start, 0);
        chk("rst_dump_done", dump_done, 0);
        chk("rst_small_cnt", frame_cnt4, 0);
        rst = 1'b0;

        // FREE channel opens one clock after release
        step(1'b0, 1'b1);
        chk("free_en", dump_en[2], 1);
        chk("free_start", dump_start[2], 1);

        // FRAME start=3 len=2 over six frames
        for (int i = 1; i <= 6; i++) begin
            frame(1'b1);
            chk("ch0_en", dump_en[0], (i == 3 || i == 4));
            chk("ch0_start", dump_start[0], (i == 3));
        end
        chk("ch0_done", dump_done[0], 1);
        frame(1'b1);
        chk("cnt7", frame_cnt, 7);

        // download end restarts counting; POSTLOAD start=2 unlimited
        step(1'b0, 1'b0);
        chk("dl_restart", frame_cnt, 0);
        for (int i = 1; i <= 22; i++) begin
            frame(1'b0);
            chk("ch1_en", dump_en[1], (i >= 2));
        end

        // coincident download end and VS fall at frame 9
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 9; i++) frame(1'b0);
        chk("cnt9", frame_cnt, 9);
        step(1'b1, 1'b1);
        chk("ch1_dropped", dump_en[1], 0);
        step(1'b0, 1'b0);
        chk("coincident_cnt", frame_cnt, 0);
        frame(1'b0);
        frame(1'b0);
        chk("ch1_rearmed", dump_en[1], 1);

        // OFF on an active FRAME channel
        set_ch(0, 0, 0, 0);
        step(1'b0, 1'b0);
        chk("off_done_clear", dump_done[0], 0);
        set_ch(0, 1, 4, 3);
        step(1'b0, 1'b0);
        frame(1'b0);
        frame(1'b0);
        chk("ch0_reopen", dump_en[0], 1);
        set_ch(0, 0, 4, 3);
        step(1'b0, 1'b0);
        chk("off_en", dump_en[0], 0);
        chk("off_start", dump_start[0], 0);
        chk("off_done", dump_done[0], 0);

        // asynchronous reset in the middle of a window
        set_ch(0, 1, 3, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_en", dump_en, 0);
        chk("async_cnt", frame_cnt, 0);
        chk("async_done", dump_done, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0);

        // four-bit counter wraps; window only at the first frame 1
        n4 = 0;
        for (int i = 1; i <= 17; i++) begin
            vs4 = 1'b1;
            step(1'b0, 1'b0);
            vs4 = 1'b0;
            step(1'b0, 1'b0);
            n4 += int'(st4);
            chk("wrap_cnt", frame_cnt4, i % 16);
            chk("wrap_en", en4, (i == 1 || i == 2));
        end
        chk("wrap_starts", n4, 1);
        chk("wrap_done", dn4, 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic d;
            d = dwnld;
            if ($urandom_range(0, 49) == 0)
                set_ch($urandom_range(0, CH-1), $urandom_range(0, 3),
                       $urandom_range(0, 10), $urandom_range(0, 4));
            if ($urandom_range(0, 59) == 0) d = ~d;
            step(1'($urandom_range(0, 1)), d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
